// File: rtl/sram_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pipe
//   Single-port SRAM controller built around an inferred word array.
//   Requests arrive on a valid/ready channel. Every request, read or write,
//   returns exactly one in-order response on a valid/ready channel.
//   Each request travels through an RD_LAT-deep latency pipeline and then into
//   a small response FIFO. The FIFO head drives rsp_* directly.
//   A credit counter caps the number of outstanding requests (in flight plus
//   queued) at RSP_DEPTH. As a result, the FIFO cannot overflow and the
//   pipeline never has to stall.
//
// Parameters
//   DATA_W    data width in bits (multiple of 8)
//   ADDR_W    word-address width
//   DEPTH     implemented words (<= 2**ADDR_W); addresses >= DEPTH are errors
//   RD_LAT    accept-to-FIFO latency in cycles (1..4)
//   RSP_DEPTH maximum outstanding requests
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_write, req_addr              1 = write / word address
//   req_wdata, req_be                write data and byte enables
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata                        read data (0 for writes and errors)
//   rsp_write, rsp_err               response is for a write / bad address
// -----------------------------------------------------------------------------
module sram_ctrl_pipe #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 13,
   parameter int DEPTH     = 2048,
   parameter int RD_LAT    = 1,
   parameter int RSP_DEPTH = RD_LAT + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_write,
   output logic                  rsp_err
);

   localparam int NB     = DATA_W / 8;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW     = $clog2(RSP_DEPTH + 1);

   localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W + 1)'(DEPTH);
   localparam logic [CW-1:0]   C_CREDITS  = CW'(RSP_DEPTH);
   localparam logic [PW-1:0]   C_PTR_LAST = PW'(RSP_DEPTH - 1);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Latency pipeline: index k holds stage k (stage 0 is loaded at the accept edge)
   logic [RD_LAT-1:0] r_vld_p;
   logic              r_wr_p   [RD_LAT];
   logic              r_err_p  [RD_LAT];
   logic [DATA_W-1:0] r_data_p [RD_LAT];

   logic [DATA_W-1:0] r_fifo_data [RSP_DEPTH];
   logic              r_fifo_wr   [RSP_DEPTH];
   logic              r_fifo_err  [RSP_DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_fcnt;
   logic [CW-1:0]     r_count;

   logic              w_accept;
   logic              w_in_range;
   logic              w_push;
   logic              w_pop;
   logic [MEM_AW-1:0] w_mem_addr;

   // Credits come from the registered count alone, so there is no
   // combinational path from rsp_ready or req_valid to req_ready.
   assign req_ready  = (r_count < C_CREDITS);
   assign w_accept   = req_valid && req_ready;
   assign w_in_range = ({1'b0, req_addr} < C_DEPTH);
   assign w_mem_addr = req_addr[MEM_AW-1:0];
   assign w_push     = r_vld_p[RD_LAT-1];
   assign w_pop      = rsp_valid && rsp_ready;

   // ---- stage 0: array access at the accept edge, then shift toward the FIFO
   always_ff @(posedge clk) begin
      if (w_accept && req_write && w_in_range) begin
         for (int b = 0; b < NB; b++) begin
            if (req_be[b]) begin
               r_mem[w_mem_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
         end
      end
      if (w_accept) begin
         r_wr_p[0]   <= req_write;
         r_err_p[0]  <= !w_in_range;
         r_data_p[0] <= (!req_write && w_in_range) ? r_mem[w_mem_addr] : '0;
      end
      for (int k = 1; k < RD_LAT; k++) begin
         r_wr_p[k]   <= r_wr_p[k-1];
         r_err_p[k]  <= r_err_p[k-1];
         r_data_p[k] <= r_data_p[k-1];
      end
   end

   // ---- stage RD_LAT: last pipeline stage lands in the response FIFO
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wptr] <= r_data_p[RD_LAT-1];
         r_fifo_wr[r_wptr]   <= r_wr_p[RD_LAT-1];
         r_fifo_err[r_wptr]  <= r_err_p[RD_LAT-1];
      end
   end

   // Control state: valid bits, credit counter and FIFO pointers.
   // Reset drops anything in flight without producing a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p <= '0;
         r_count <= '0;
         r_fcnt  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         r_vld_p[0] <= w_accept;
         for (int k = 1; k < RD_LAT; k++) begin
            r_vld_p[k] <= r_vld_p[k-1];
         end

         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + CW'(1);
            2'b01:   r_fcnt <= r_fcnt - CW'(1);
            default: r_fcnt <= r_fcnt;
         endcase

         if (w_push) begin
            r_wptr <= (r_wptr == C_PTR_LAST) ? '0 : r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == C_PTR_LAST) ? '0 : r_rptr + PW'(1);
         end
      end
   end

   // Head of FIFO drives the response. Gating with rsp_valid keeps the outputs
   // at 0 after reset even though the FIFO storage itself is not reset.
   assign rsp_valid = (r_fcnt != '0);
   assign rsp_rdata = rsp_valid ? r_fifo_data[r_rptr] : '0;
   assign rsp_write = rsp_valid ? r_fifo_wr[r_rptr]   : 1'b0;
   assign rsp_err   = rsp_valid ? r_fifo_err[r_rptr]  : 1'b0;

`ifndef SYNTHESIS
   a_rd_lat_legal: assert property (@(posedge clk) (RD_LAT >= 1 && RD_LAT <= 4))
      else $error("sram_ctrl_pipe: RD_LAT=%0d outside 1..4", RD_LAT);

   // A stalled request must stay asserted and unchanged until accepted.
   a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid && !req_ready) |=> (req_valid && $stable(req_write) &&
         $stable(req_addr) && $stable(req_wdata) && $stable(req_be)))
      else $error("sram_ctrl_pipe: request changed while stalled");
`endif

endmodule

// File: tb/tb_sram_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl_pipe
//   Three instances of sram_ctrl_pipe share one clock and reset:
//     dut 0 : RD_LAT=1, RSP_DEPTH=2
//     dut 1 : RD_LAT=2, RSP_DEPTH=3
//     dut 2 : RD_LAT=4, RSP_DEPTH=6
//   On dut 2, the extra credit covers the cycle between a pop and the
//   returned credit, so a stream never throttles.
//   Inputs change 2 ns after the rising edge. Outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_sram_ctrl_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid [3];
   logic        req_write [3];
   logic        rsp_ready [3];
   logic [12:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic        req_ready [3];
   logic        rsp_valid [3];
   logic        rsp_write [3];
   logic        rsp_err   [3];
   logic [31:0] rsp_rdata [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sram_ctrl_pipe #(
         .DATA_W   (32),
         .ADDR_W   (13),
         .DEPTH    (2048),
         .RD_LAT   ((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
         .RSP_DEPTH((g == 0) ? 2 : ((g == 1) ? 3 : 6))
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .req_valid(req_valid[g]),
         .req_ready(req_ready[g]),
         .req_write(req_write[g]),
         .req_addr (req_addr[g]),
         .req_wdata(req_wdata[g]),
         .req_be   (req_be[g]),
         .rsp_valid(rsp_valid[g]),
         .rsp_ready(rsp_ready[g]),
         .rsp_rdata(rsp_rdata[g]),
         .rsp_write(rsp_write[g]),
         .rsp_err  (rsp_err[g])
      );
   end

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] data;
      bit          chk_lat;
      int          exp_cyc;
   } rsp_t;

   typedef struct {
      logic        wr;
      logic [12:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   act    = 0;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_chk++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int d, input logic wr, input logic err, input logic [31:0] data,
                           input bit chk_lat);
      rsp_t e;
      e.wr      = wr;
      e.err     = err;
      e.data    = data;
      e.chk_lat = chk_lat;
      e.exp_cyc = cyc + lat_of(d);
      exp_q.push_back(e);
   endtask

   // Presents one request and returns after the edge that accepted it.
   task automatic send(input int d, input logic wr, input logic [12:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic e_err, input logic [31:0] e_data,
                       input bit chk_lat, output int acc_cyc, output int waits);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_be[d]    = be;
      waits = 0;
      while (!req_ready[d] && waits < 50) begin
         tick();
         waits++;
      end
      if (!req_ready[d]) begin
         n_chk++;
         $display("FAIL accept_timeout: dut %0d addr %h req_ready=0 after %0d cycles, expected 1",
                  d, a, waits);
         req_valid[d] = 1'b0;
         acc_cyc = cyc;
         return;
      end
      tick();
      acc_cyc = cyc;
      push_exp(d, wr, e_err, e_data, chk_lat);
      req_valid[d] = 1'b0;
   endtask

   task automatic req(input int d, input logic wr, input logic [12:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic e_err, input logic [31:0] e_data,
                      input bit chk_lat);
      int acc;
      int w;
      send(d, wr, a, wd, be, e_err, e_data, chk_lat, acc, w);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   // Response scoreboard: every handshake must match the oldest expectation
   // of the instance under test.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (rsp_valid[d] && rsp_ready[d]) begin
               n_seen++;
               if (d != act || exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL rsp_unexpected: dut %0d rdata %h write %0b err %0b, expected no response",
                           d, rsp_rdata[d], rsp_write[d], rsp_err[d]);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("rsp_fields", {30'd0, rsp_write[d], rsp_err[d], rsp_rdata[d]},
                        {30'd0, mon_e.wr, mon_e.err, mon_e.data});
                  if (mon_e.chk_lat) check("rsp_latency", 64'(cyc), 64'(mon_e.exp_cyc));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      int   idx;
      bit   go;
      int   acc;
      int   w;
      int   first;
      int   last;
      int   waits_tot;
      int   n0;
      logic [31:0] sd;

      for (int d = 0; d < 3; d++) begin
         req_valid[d] = 1'b0;
         req_write[d] = 1'b0;
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         req_be[d]    = '0;
         rsp_ready[d] = 1'b1;
      end

      // Reset state
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("reset_req_ready", 64'(req_ready[0]), 64'(1));
      check("reset_rsp_valid", 64'(rsp_valid[0]), 64'(0));
      check("reset_rsp_rdata", 64'(rsp_rdata[0]), 64'(0));
      check("reset_rsp_write", 64'(rsp_write[0]), 64'(0));
      check("reset_rsp_err",   64'(rsp_err[0]),   64'(0));

      // Table: basic access, byte masks, errors and range boundaries on dut 0.
      tbl[0]  = '{1'b1, 13'h005,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 13'h005,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 13'h005,  32'h11223344, 4'h5, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 13'h005,  32'h0,        4'h0, 1'b0, 32'hDE22BE44};
      tbl[4]  = '{1'b1, 13'h005,  32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 13'h005,  32'h0,        4'h0, 1'b0, 32'hDE22BE44};
      tbl[6]  = '{1'b1, 13'h000,  32'h0A0B0C0D, 4'hF, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 13'h800,  32'h0,        4'h0, 1'b1, 32'h0};
      tbl[8]  = '{1'b1, 13'h800,  32'h12345678, 4'hF, 1'b1, 32'h0};
      tbl[9]  = '{1'b1, 13'h7FF,  32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 13'h7FF,  32'h0,        4'h0, 1'b0, 32'hCAFEF00D};
      tbl[11] = '{1'b0, 13'h000,  32'h0,        4'h0, 1'b0, 32'h0A0B0C0D};
      tbl[12] = '{1'b0, 13'h1FFF, 32'h0,        4'h0, 1'b1, 32'h0};
      tbl[13] = '{1'b1, 13'h006,  32'h01020304, 4'hF, 1'b0, 32'h0};
      tbl[14] = '{1'b1, 13'h006,  32'hA0B0C0D0, 4'hA, 1'b0, 32'h0};
      tbl[15] = '{1'b0, 13'h006,  32'h0,        4'h0, 1'b0, 32'hA002C004};

      act = 0;
      for (int i = 0; i < 16; i++) begin
         req(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].e_err, tbl[i].e_rdata, 1'b1);
      end
      drain();

      // Back-pressure on dut 1 (RD_LAT=2, three credits)
      act = 1;
      for (int i = 0; i < 5; i++) begin
         req(1, 1'b1, 13'(10 + i), 32'h10000000 + 32'(10 + i), 4'hF, 1'b0, 32'h0, 1'b1);
      end
      drain();

      rsp_ready[1] = 1'b0;
      req_valid[1] = 1'b1;
      req_write[1] = 1'b0;
      req_addr[1]  = 13'd10;
      req_wdata[1] = '0;
      req_be[1]    = '0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         go = req_ready[1];
         tick();
         if (go) begin
            push_exp(1, 1'b0, 1'b0, 32'h10000000 + 32'(10 + idx), 1'b0);
            idx++;
            req_addr[1] = 13'(10 + idx);
         end
      end
      check("bp_accepted", 64'(idx), 64'(3));
      check("bp_ready_low", 64'(req_ready[1]), 64'(0));
      check("bp_head_hold", {31'd0, rsp_valid[1], rsp_rdata[1]}, {31'd0, 1'b1, 32'h1000000A});

      rsp_ready[1] = 1'b1;
      check("bp_ready_before_pop", 64'(req_ready[1]), 64'(0));
      tick();
      check("bp_ready_after_pop", 64'(req_ready[1]), 64'(1));
      for (int c = 0; c < 20 && idx < 5; c++) begin
         go = req_ready[1];
         tick();
         if (go) begin
            push_exp(1, 1'b0, 1'b0, 32'h10000000 + 32'(10 + idx), 1'b0);
            idx++;
            req_addr[1] = 13'(10 + idx);
         end
      end
      req_valid[1] = 1'b0;
      check("bp_all_accepted", 64'(idx), 64'(5));
      drain();

      // Streaming on dut 2 (RD_LAT=4): write/read pairs back to back
      act = 2;
      waits_tot = 0;
      first = 0;
      last = 0;
      n0 = n_seen;
      for (int i = 0; i < 16; i++) begin
         sd = 32'hC0DE0000 + 32'(i) * 32'h00010203;
         send(2, 1'b1, 13'(13'h100 + i), sd, 4'hF, 1'b0, 32'h0, 1'b1, acc, w);
         if (i == 0) first = acc;
         waits_tot += w;
         send(2, 1'b0, 13'(13'h100 + i), 32'h0, 4'h0, 1'b0, sd, 1'b1, acc, w);
         waits_tot += w;
         last = acc;
      end
      check("stream_span", 64'(last - first), 64'(31));
      check("stream_stalls", 64'(waits_tot), 64'(0));
      drain();
      check("stream_rsp_count", 64'(n_seen - n0), 64'(32));

      // Reset with two requests outstanding on dut 0
      act = 0;
      rsp_ready[0] = 1'b0;
      req(0, 1'b0, 13'h005, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0);
      req(0, 1'b0, 13'h7FF, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", 64'(rsp_valid[0]), 64'(0));
      check("rst_rsp_rdata", 64'(rsp_rdata[0]), 64'(0));
      exp_q.delete();
      rsp_ready[0] = 1'b1;
      tick();
      rst_n = 1'b1;
      n0 = n_seen;
      repeat (8) tick();
      check("rst_no_stale", 64'(n_seen - n0), 64'(0));
      check("rst_ready", 64'(req_ready[0]), 64'(1));
      req(0, 1'b0, 13'h006, 32'h0, 4'h0, 1'b0, 32'hA002C004, 1'b1);
      req(0, 1'b0, 13'h000, 32'h0, 4'h0, 1'b0, 32'h0A0B0C0D, 1'b1);
      drain();

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
